beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//   Beat/phase timing generator for the hardwired controller. Produces the one-hot
//   machine-cycle beats W[3:1] and the ST0 phase flag that the controller decodes.
//   Honours the controller's SHORT/LONG/STOP/SST0 feedback. Supports start (QD),
//   single-cycle stepping and console-mode (SW) abort. Sits between the console and
//   the controller.
// PARAMETERS
//   CNT_W   8   width of completed-machine-cycle counter CYC_CNT
// PORTS
//   T3       in   1      clock; every beat advances on the rising edge
//   CLR      in   1      asynchronous, active-low reset
//   QD       in   1      start button, synchronous to T3, already debounced
//   SW       in   3      console mode; 000 = run program, others = console ops
//   SINGLE   in   1      1 = stop after every machine cycle
//   STOP     in   1      controller: halt at end of current beat
//   SHORT    in   1      controller: end cycle after W1
//   LONG     in   1      controller: extend cycle to W3
//   SST0     in   1      controller: set ST0 at end of cycle
//   W        out  3      one-hot beat {W3,W2,W1}; 000 when idle
//   ST0      out  1      phase flag
//   RUN      out  1      1 while W != 000
//   CYC_CNT  out  CNT_W  completed machine cycles, wraps
// BEHAVIOUR
//   - Reset (CLR=0, async): state IDLE, W=000, ST0=0, RUN=0, CYC_CNT=0, qd_d=0,
//     mode_q=000. All outputs are registered.
//   - Start: qd_rise = QD & ~qd_d; qd_d <= QD every cycle. In IDLE, qd_rise moves
//     to W1 on the next edge and latches mode_q <= SW. QD ignored outside IDLE.
//   - FSM (one-hot W = state; evaluated at each T3 edge while not IDLE):
//     W1: ->IDLE if STOP; else ->W1 if SHORT (cycle end); else ->W2.
//     W2: ->IDLE if STOP; else ->W3 if LONG; else ->W1 (cycle end).
//     W3: ->IDLE if STOP; else ->W1 (cycle end).
//   - SHORT is ignored in W2/W3; LONG is ignored in W1/W3 (SHORT wins in W1).
//   - Cycle end = the exits listed above, plus any STOP exit. Exception: a STOP
//     exit from W1 while LONG=1 and SHORT=0 also counts.
//     At cycle end: CYC_CNT += 1 (mod 2^CNT_W). ST0 <= 1 if SST0, else ST0 holds.
//   - SINGLE=1: every cycle-end transition goes to IDLE instead of W1. Counter and
//     ST0 updates still apply. A new qd_rise is needed to continue.
//   - Abort: if SW != mode_q in any non-IDLE state, go to IDLE on that edge.
//     Also: ST0 <= 0, no count, STOP/SHORT/LONG/SST0 ignored.
//     Priority: abort > STOP > SINGLE > SHORT/LONG.
//   - ST0 is cleared only by CLR or abort. It persists across STOP/restart.
//   - Latency: qd_rise -> W1 visible one edge later. STOP -> W=000 on the edge that
//     ends the current beat.
//   - CLR mid-cycle: immediate return to reset values, no count.
// TESTING
//   1 CLR low -> W=000, ST0=0, RUN=0, CYC_CNT=0. QD pulse, then plain cycles ->
//     W: 001,010,001,010... CYC_CNT +1 every 2 beats.
//   2 SHORT=1 held -> W stays 001, CYC_CNT +1 each edge. LONG=1 -> 001,010,100
//     repeat, CYC_CNT +1 every 3 beats.
//   3 SST0=1 asserted in W2 of cycle 1 -> ST0=1 after that edge and stays 1.
//     Then STOP in W1 -> W=000, ST0 still 1. Restart with QD -> ST0=1.
//   4 SINGLE=1, QD pulse -> exactly one cycle (001,010) then W=000, CYC_CNT +1.
//     QD held high -> no second cycle until QD falls and rises again.
//   5 SW 000->001 during W2 while STOP=1, SST0=1 -> W=000, ST0=0, CYC_CNT unchanged.
//   6 CNT_W=8, run 256 cycles -> CYC_CNT wraps to 0. CLR pulsed in W2 ->
//     immediate reset values.

Source files
------------

// File: rtl/beat_sequencer_if.sv
// rtl/beat_sequencer_if.sv - console/controller <-> beat sequencer signal bundle
interface beat_sequencer_if #(
  parameter int CNT_W = 8
) ();
  logic             qd;
  logic [2:0]       sw;
  logic             single;
  logic             stop;
  logic             short;
  logic             long;
  logic             sst0;
  logic [2:0]       w;
  logic             st0;
  logic             run;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output qd, sw, single, stop, short, long, sst0,
    input  w, st0, run, cyc_cnt
  );

  modport slave (
    input  qd, sw, single, stop, short, long, sst0,
    output w, st0, run, cyc_cnt
  );
endinterface

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - one-hot machine-cycle beat generator with ST0 phase flag
module beat_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic              t3,
  input  logic              clr,
  beat_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    BEAT1 = 3'b001,
    BEAT2 = 3'b010,
    BEAT3 = 3'b100
  } state_t;

  state_t           state;
  state_t           next_beat;
  logic             st0_q;
  logic             run_q;
  logic             qd_d;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             qd_rise;
  logic             abort;
  logic             cyc_end;

  // Next beat and cycle-end decode for the running case; abort is resolved in the FSM.
  always_comb begin
    qd_rise   = bus.qd & ~qd_d;
    abort     = (state != IDLE) && (bus.sw != mode_q);
    cyc_end   = 1'b0;
    next_beat = IDLE;
    case (state)
      BEAT1: begin
        if (bus.short) begin
          cyc_end   = 1'b1;
          next_beat = BEAT1;
        end else begin
          next_beat = BEAT2;
        end
      end
      BEAT2: begin
        if (bus.long) begin
          next_beat = BEAT3;
        end else begin
          cyc_end   = 1'b1;
          next_beat = BEAT1;
        end
      end
      BEAT3: begin
        cyc_end   = 1'b1;
        next_beat = BEAT1;
      end
      default: begin
        cyc_end   = 1'b0;
        next_beat = IDLE;
      end
    endcase
    if ((state != IDLE) && bus.stop) begin
      cyc_end   = 1'b1;
      next_beat = IDLE;
    end
    if (cyc_end && bus.single) begin
      next_beat = IDLE;
    end
  end

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      st0_q  <= 1'b0;
      run_q  <= 1'b0;
      qd_d   <= 1'b0;
      mode_q <= 3'b000;
      cnt_q  <= '0;
    end else begin
      qd_d <= bus.qd;
      if (state == IDLE) begin
        if (qd_rise) begin
          state  <= BEAT1;
          run_q  <= 1'b1;
          mode_q <= bus.sw;
        end
      end else if (abort) begin
        state <= IDLE;
        run_q <= 1'b0;
        st0_q <= 1'b0;
      end else begin
        state <= next_beat;
        run_q <= (next_beat != IDLE);
        if (cyc_end) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.sst0) begin
            st0_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.w       = state;
  assign bus.st0     = st0_q;
  assign bus.run     = run_q;
  assign bus.cyc_cnt = cnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - self-checking bench for beat_sequencer
module tb_beat_sequencer;

  logic t3;
  logic clr;
  int   errors;
  int   checks;

  beat_sequencer_if #(.CNT_W(8)) bif ();

  beat_sequencer #(.CNT_W(8)) dut (
    .t3  (t3),
    .clr (clr),
    .bus (bif.slave)
  );

  initial begin
    t3 = 1'b0;
    forever #5 t3 = ~t3;
  end

  typedef struct {
    logic       qd;
    logic [2:0] sw;
    logic       single;
    logic       stop;
    logic       shrt;
    logic       lng;
    logic       sst0;
    logic [2:0] w;
    logic       st0;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[25];

  // Reference model: beat number 0 (idle) .. 3, plus phase flag and cycle tally
  int         m_beat;
  logic       m_st0;
  int         m_cnt;
  logic       m_qd_d;
  logic [2:0] m_mode;

  function automatic vec_t mk(logic qd, logic [2:0] sw, logic single, logic stop,
                              logic shrt, logic lng, logic sst0,
                              logic [2:0] w, logic st0, logic [7:0] cnt);
    vec_t v;
    v.qd = qd; v.sw = sw; v.single = single; v.stop = stop;
    v.shrt = shrt; v.lng = lng; v.sst0 = sst0;
    v.w = w; v.st0 = st0; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge t3);
    #1;
  endtask

  task automatic set_in(input logic qd, input logic [2:0] sw, input logic single,
                        input logic stop, input logic shrt, input logic lng,
                        input logic sst0);
    bif.qd = qd; bif.sw = sw; bif.single = single; bif.stop = stop;
    bif.short = shrt; bif.long = lng; bif.sst0 = sst0;
  endtask

  task automatic do_reset();
    set_in(0, 3'b000, 0, 0, 0, 0, 0);
    @(negedge t3);
    clr = 1'b0;
    @(negedge t3);
    clr = 1'b1;
    m_beat = 0; m_st0 = 0; m_cnt = 0; m_qd_d = 0; m_mode = 3'b000;
  endtask

  task automatic model_edge();
    bit ends;
    int nxt;
    if (m_beat == 0) begin
      if (bif.qd && !m_qd_d) begin
        m_beat = 1;
        m_mode = bif.sw;
      end
    end else if (bif.sw != m_mode) begin
      m_beat = 0;
      m_st0  = 0;
    end else begin
      ends = 0;
      nxt  = 0;
      if (bif.stop) begin
        ends = 1;
        nxt  = 0;
      end else if (m_beat == 1) begin
        if (bif.short) begin ends = 1; nxt = 1; end
        else nxt = 2;
      end else if (m_beat == 2) begin
        if (bif.long) nxt = 3;
        else begin ends = 1; nxt = 1; end
      end else begin
        ends = 1;
        nxt  = 1;
      end
      if (ends && bif.single) nxt = 0;
      if (ends) begin
        m_cnt = (m_cnt + 1) % 256;
        if (bif.sst0) m_st0 = 1;
      end
      m_beat = nxt;
    end
    m_qd_d = bif.qd;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr    = 1'b0;
    set_in(0, 3'b000, 0, 0, 0, 0, 0);

    //             qd sw     sgl stp sh lg s0   w       st0 cnt
    vecs[0]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 0, 8'd0);
    vecs[1]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 0, 8'd0);
    vecs[2]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b001, 0, 8'd1);
    vecs[3]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 0, 8'd1);
    vecs[4]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b001, 0, 8'd2);
    vecs[5]  = mk(0, 3'b000, 0, 0, 1, 0, 0, 3'b001, 0, 8'd3);
    vecs[6]  = mk(0, 3'b000, 0, 0, 1, 0, 0, 3'b001, 0, 8'd4);
    vecs[7]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 3'b010, 0, 8'd4);
    vecs[8]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 3'b100, 0, 8'd4);
    vecs[9]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 3'b001, 0, 8'd5);
    vecs[10] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 0, 8'd5);
    vecs[11] = mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 8'd6);
    vecs[12] = mk(0, 3'b000, 0, 1, 0, 0, 0, 3'b000, 1, 8'd7);
    vecs[13] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 8'd7);
    vecs[14] = mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 1, 8'd7);
    vecs[15] = mk(0, 3'b000, 1, 0, 0, 0, 0, 3'b010, 1, 8'd7);
    vecs[16] = mk(0, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 8'd8);
    vecs[17] = mk(1, 3'b000, 1, 0, 0, 0, 0, 3'b001, 1, 8'd8);
    vecs[18] = mk(1, 3'b000, 1, 0, 0, 0, 0, 3'b010, 1, 8'd8);
    vecs[19] = mk(1, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 8'd9);
    vecs[20] = mk(1, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 8'd9);
    vecs[21] = mk(0, 3'b000, 1, 0, 0, 0, 0, 3'b000, 1, 8'd9);
    vecs[22] = mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 1, 8'd9);
    vecs[23] = mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 8'd9);
    vecs[24] = mk(0, 3'b001, 0, 1, 0, 0, 1, 3'b000, 0, 8'd9);

    #12;
    chk("reset_w",   32'(bif.w),       32'd0);
    chk("reset_st0", 32'(bif.st0),     32'd0);
    chk("reset_run", 32'(bif.run),     32'd0);
    chk("reset_cnt", 32'(bif.cyc_cnt), 32'd0);
    @(negedge t3);
    clr = 1'b1;

    for (int i = 0; i < 25; i++) begin
      set_in(vecs[i].qd, vecs[i].sw, vecs[i].single, vecs[i].stop,
             vecs[i].shrt, vecs[i].lng, vecs[i].sst0);
      tick();
      chk($sformatf("vec%0d_w", i),   32'(bif.w),       32'(vecs[i].w));
      chk($sformatf("vec%0d_st0", i), 32'(bif.st0),     32'(vecs[i].st0));
      chk($sformatf("vec%0d_run", i), 32'(bif.run),     32'(vecs[i].w != 3'b000));
      chk($sformatf("vec%0d_cnt", i), 32'(bif.cyc_cnt), 32'(vecs[i].cnt));
    end

    // Counter wrap with SHORT held, then asynchronous CLR in the middle of W2
    do_reset();
    set_in(1, 3'b000, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 3'b000, 0, 0, 1, 0, 0);
    repeat (255) tick();
    chk("wrap_255_cnt", 32'(bif.cyc_cnt), 32'd255);
    chk("wrap_255_w",   32'(bif.w),       32'd1);
    tick();
    chk("wrap_0_cnt",   32'(bif.cyc_cnt), 32'd0);
    set_in(0, 3'b000, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 3'b000, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 3'b000, 0, 0, 0, 0, 0);
    tick();
    chk("preclr_w",   32'(bif.w),       32'd2);
    chk("preclr_st0", 32'(bif.st0),     32'd1);
    chk("preclr_cnt", 32'(bif.cyc_cnt), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_w",   32'(bif.w),       32'd0);
    chk("clr_st0", 32'(bif.st0),     32'd0);
    chk("clr_run", 32'(bif.run),     32'd0);
    chk("clr_cnt", 32'(bif.cyc_cnt), 32'd0);
    @(negedge t3);
    clr = 1'b1;

    // Randomised run against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] sw_n;
      sw_n = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : bif.sw;
      if ($urandom_range(0, 3) == 0 && sw_n != 3'b000 && m_beat == 0) sw_n = 3'b000;
      set_in(($urandom_range(0, 2) == 0), sw_n,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0));
      tick();
      model_edge();
      chk("rand_w",   32'(bif.w),       (m_beat == 0) ? 32'd0 : (32'd1 << (m_beat - 1)));
      chk("rand_st0", 32'(bif.st0),     32'(m_st0));
      chk("rand_run", 32'(bif.run),     32'(m_beat != 0));
      chk("rand_cnt", 32'(bif.cyc_cnt), 32'(m_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
